// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register target feeding pwm_peripheral.
// Frame layout, register addresses, reset value and frame-state encoding.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam logic [7:0] REG_RESET = 8'h00;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } spi_frame_t;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } spi_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle rise/fall
// pulses taken between the last synchronizer stage and one extra history flop.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target writing the five pwm_peripheral control registers from 16-bit frames.
// Define SPI_READBACK_EN to add the cipo pin and register readback on read frames.
module spi_peripheral
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
`ifdef SPI_READBACK_EN
    output logic       cipo,
`endif
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sclk_level;
    logic w_ncs_level;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_copi;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (sclk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (ncs),
        .o_level (w_ncs_level),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (copi),
        .o_level (w_copi),
        .o_rise  (),
        .o_fall  ()
    );

    spi_state_t r_state;
    spi_state_t w_state_nxt;
    logic [15:0] r_shreg;
    logic [4:0]  r_bit_cnt;
    logic        r_overflow;
    spi_frame_t  w_frame;
    logic        w_shift_en;
    logic        w_commit;

    logic [7:0] r_en_out_lo;
    logic [7:0] r_en_out_hi;
    logic [7:0] r_en_pwm_lo;
    logic [7:0] r_en_pwm_hi;
    logic [7:0] r_duty;

    assign w_frame = spi_frame_t'(r_shreg);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A frame only opens on a fresh ncs fall, so sclk activity left over from a reset is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_state_nxt = ST_FRAME;
                end
            end
            ST_FRAME: begin
                w_shift_en = w_sclk_rise & w_sclk_level & ~w_ncs_level;
                if (w_ncs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_commit    = (r_bit_cnt == 5'(FRAME_BITS)) & ~r_overflow &
                                  w_frame.rw & (w_frame.addr <= MAX_ADDR);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (w_ncs_fall) begin
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (w_shift_en) begin
            if (r_bit_cnt == 5'(FRAME_BITS)) begin
                r_overflow <= 1'b1;
            end else begin
                r_shreg   <= {r_shreg[14:0], w_copi};
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_out_lo <= REG_RESET;
            r_en_out_hi <= REG_RESET;
            r_en_pwm_lo <= REG_RESET;
            r_en_pwm_hi <= REG_RESET;
            r_duty      <= REG_RESET;
        end else if (w_commit) begin
            case (w_frame.addr)
                ADDR_EN_OUT_LO: r_en_out_lo <= w_frame.data;
                ADDR_EN_OUT_HI: r_en_out_hi <= w_frame.data;
                ADDR_EN_PWM_LO: r_en_pwm_lo <= w_frame.data;
                ADDR_EN_PWM_HI: r_en_pwm_hi <= w_frame.data;
                ADDR_DUTY:      r_duty      <= w_frame.data;
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = r_en_out_lo;
    assign en_reg_out_15_8 = r_en_out_hi;
    assign en_reg_pwm_7_0  = r_en_pwm_lo;
    assign en_reg_pwm_15_8 = r_en_pwm_hi;
    assign pwm_duty_cycle  = r_duty;

`ifdef SPI_READBACK_EN
    logic [7:0] r_out_shift;
    logic       r_rd_frame;
    logic       r_cipo;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_data;

    // The address is complete only once the 8th bit arrives, so it is taken from the shifter plus live copi.
    always_comb begin
        w_rd_addr = {r_shreg[5:0], w_copi};
        w_rd_data = REG_RESET;
        if (w_rd_addr <= MAX_ADDR) begin
            case (w_rd_addr)
                ADDR_EN_OUT_LO: w_rd_data = r_en_out_lo;
                ADDR_EN_OUT_HI: w_rd_data = r_en_out_hi;
                ADDR_EN_PWM_LO: w_rd_data = r_en_pwm_lo;
                ADDR_EN_PWM_HI: w_rd_data = r_en_pwm_hi;
                ADDR_DUTY:      w_rd_data = r_duty;
                default:        w_rd_data = REG_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_ncs_level) begin
            r_out_shift <= '0;
            r_rd_frame  <= 1'b0;
            r_cipo      <= 1'b0;
        end else if (w_shift_en && (r_bit_cnt == 5'd7) && !r_shreg[6]) begin
            r_out_shift <= w_rd_data;
            r_rd_frame  <= 1'b1;
        end else if ((r_state == ST_FRAME) && w_sclk_fall && r_rd_frame &&
                     (r_bit_cnt >= 5'd8) && (r_bit_cnt <= 5'd15)) begin
            r_cipo      <= r_out_shift[7];
            r_out_shift <= {r_out_shift[6:0], 1'b0};
        end
    end

    assign cipo = r_cipo;
`endif

endmodule
